btn_debounce_sync: RTL and testbench

- Conditions a raw, asynchronous push-button or switch input into a clean synchronous level plus single-cycle edge pulses.
- Sits directly upstream of the synchronous-reset D flip-flop stages. Its level_o / rise_o outputs drive their d inputs, and those stages sample a glitch-free, clk-aligned signal.
- Contains a 2-flop synchronizer, a stability counter and a 4-state debounce FSM.

---
 rtl/btn_debounce_sync.sv | 111 +++++++++++
 tb/tb_btn_debounce_sync.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/btn_debounce_sync.sv
// Push-button conditioner: 2-flop synchronizer, stability counter and a
// 4-state debounce FSM producing a clean level plus one-cycle edge pulses.
module btn_debounce_sync #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned CNT_W           = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_in,
    output logic level_o,
    output logic rise_o,
    output logic fall_o,
    output logic busy_o
);

    typedef enum logic [1:0] {
        StStable0,
        StCheck1,
        StStable1,
        StCheck0
    } state_e;

    // Count value seen on the last sample of a qualifying run.
    localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    state_e           state_q, state_d;
    logic             level_q, level_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

    // Next-state: synchronizer shift plus debounce FSM driven only by sync2.
    always_comb begin
        sync1_d = btn_in;
        sync2_d = sync1_q;
        state_d = state_q;
        cnt_d   = '0;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        unique case (state_q)
            StStable0: begin
                if (sync2_q) begin
                    state_d = StCheck1;
                    cnt_d   = CNT_W'(1);
                end
            end
            StCheck1: begin
                if (!sync2_q) begin
                    state_d = StStable0;
                end else if (cnt_q == CntLast) begin
                    state_d = StStable1;
                    level_d = 1'b1;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StStable1: begin
                if (!sync2_q) begin
                    state_d = StCheck0;
                    cnt_d   = CNT_W'(1);
                end
            end
            StCheck0: begin
                if (sync2_q) begin
                    state_d = StStable1;
                end else if (cnt_q == CntLast) begin
                    state_d = StStable0;
                    level_d = 1'b0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = StStable0;
        endcase
    end

    // State registers; synchronous active-low reset overrides everything.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            state_q <= StStable0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    // Outputs come straight from flops; busy is a decode of the state register.
    always_comb begin
        level_o = level_q;
        rise_o  = rise_q;
        fall_o  = fall_q;
        busy_o  = (state_q == StCheck1) || (state_q == StCheck0);
    end

endmodule

// File: tb/tb_btn_debounce_sync.sv
// Self-checking bench for btn_debounce_sync (N=4, CNT_W=3). A run-length model
// of the debounce rule pushes expected outputs per edge; they are popped and
// compared one time unit after that edge.
module tb_btn_debounce_sync;

    localparam int unsigned N = 4;

    logic clk;
    logic rst_n;
    logic btn_in;
    logic level_o;
    logic rise_o;
    logic fall_o;
    logic busy_o;

    btn_debounce_sync #(
        .DEBOUNCE_CYCLES(N),
        .CNT_W          (3)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .btn_in (btn_in),
        .level_o(level_o),
        .rise_o (rise_o),
        .fall_o (fall_o),
        .busy_o (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic level;
        logic rise;
        logic fall;
        logic busy;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    // Model state: two-stage sample pipeline and run length at the opposite value.
    logic m_s1 = 1'b0;
    logic m_s2 = 1'b0;
    logic m_lvl = 1'b0;
    int   m_run = 0;

    int cyc = 0;
    int rise_cnt = 0;
    int fall_cnt = 0;
    int last_rise = -1;
    int last_fall = -1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    endtask

    // Apply one edge's worth of stimulus, predict, then compare after the edge.
    task automatic step(input logic btn, input logic rst);
        exp_t e;
        exp_t got;
        logic s;
        @(negedge clk);
        btn_in = btn;
        rst_n  = rst;
        e = '0;
        if (!rst) begin
            m_s1 = 1'b0;
            m_s2 = 1'b0;
            m_lvl = 1'b0;
            m_run = 0;
        end else begin
            s = m_s2;
            if (s != m_lvl) begin
                m_run++;
                if (m_run == int'(N)) begin
                    m_lvl  = s;
                    e.rise = s;
                    e.fall = ~s;
                    m_run  = 0;
                end
            end else begin
                m_run = 0;
            end
            m_s2 = m_s1;
            m_s1 = btn;
        end
        e.level = m_lvl;
        e.busy  = (m_run != 0);
        exp_q.push_back(e);
        @(posedge clk);
        cyc++;
        #1;
        if (exp_q.size() == 0) begin
            check_eq("sb_empty", 1, 0);
        end else begin
            e = exp_q.pop_front();
            got = {level_o, rise_o, fall_o, busy_o};
            check_eq("level", 32'(got.level), 32'(e.level));
            check_eq("rise", 32'(got.rise), 32'(e.rise));
            check_eq("fall", 32'(got.fall), 32'(e.fall));
            check_eq("busy", 32'(got.busy), 32'(e.busy));
        end
        if (rise_o && fall_o) check_eq("rise_fall_excl", 1, 0);
        if (rise_o) begin
            rise_cnt++;
            last_rise = cyc;
        end
        if (fall_o) begin
            fall_cnt++;
            last_fall = cyc;
        end
    endtask

    initial begin
        int r0;
        int f0;
        int e_edge;
        btn_in = 1'b1;
        rst_n  = 1'b0;

        // 1. Button held through reset, then released from reset.
        repeat (3) step(1'b1, 1'b0);
        check_eq("rst_level", 32'(level_o), 0);
        check_eq("rst_busy", 32'(busy_o), 0);
        r0 = rise_cnt;
        step(1'b1, 1'b1);
        e_edge = cyc;
        repeat (8) step(1'b1, 1'b1);
        check_eq("rst_rise_count", 32'(rise_cnt - r0), 1);
        check_eq("rst_rise_cycle", 32'(last_rise), 32'(e_edge + 5));
        check_eq("rst_level_hold", 32'(level_o), 1);

        // 4. Clean release.
        f0 = fall_cnt;
        step(1'b0, 1'b1);
        e_edge = cyc;
        repeat (8) step(1'b0, 1'b1);
        check_eq("rel_fall_count", 32'(fall_cnt - f0), 1);
        check_eq("rel_fall_cycle", 32'(last_fall), 32'(e_edge + 5));
        check_eq("rel_level", 32'(level_o), 0);

        // 2. Clean press.
        r0 = rise_cnt;
        f0 = fall_cnt;
        step(1'b1, 1'b1);
        e_edge = cyc;
        repeat (8) step(1'b1, 1'b1);
        check_eq("press_rise_count", 32'(rise_cnt - r0), 1);
        check_eq("press_rise_cycle", 32'(last_rise), 32'(e_edge + 5));
        check_eq("press_no_fall", 32'(fall_cnt - f0), 0);
        repeat (8) step(1'b0, 1'b1);

        // 3. Glitch of three sampled cycles is rejected.
        r0 = rise_cnt;
        repeat (3) step(1'b1, 1'b1);
        repeat (8) step(1'b0, 1'b1);
        check_eq("glitch_no_rise", 32'(rise_cnt - r0), 0);
        check_eq("glitch_level", 32'(level_o), 0);

        // 5. Bounce, then settle high.
        r0 = rise_cnt;
        for (int i = 0; i < 10; i++) step(((i % 2) == 0) ? 1'b1 : 1'b0, 1'b1);
        step(1'b1, 1'b1);
        e_edge = cyc;
        check_eq("bounce_quiet", 32'(rise_cnt - r0), 0);
        repeat (8) step(1'b1, 1'b1);
        check_eq("bounce_rise_count", 32'(rise_cnt - r0), 1);
        check_eq("bounce_rise_cycle", 32'(last_rise), 32'(e_edge + 5));
        repeat (8) step(1'b0, 1'b1);

        // 6. Reset lands while qualifying (CHECK1, cnt=2).
        r0 = rise_cnt;
        repeat (4) step(1'b1, 1'b1);
        check_eq("mid_busy_before", 32'(busy_o), 1);
        step(1'b0, 1'b0);
        check_eq("mid_busy_after", 32'(busy_o), 0);
        check_eq("mid_cnt_after", 32'(dut.cnt_q), 0);
        repeat (8) step(1'b0, 1'b1);
        check_eq("mid_no_rise", 32'(rise_cnt - r0), 0);

        check_eq("sb_drained", 32'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
